myspi_master: RTL

MYSPI_MASTER -- requirements
Module: myspi_master

---
 rtl/myspi_pkg.sv | 25 ++
 rtl/myspi_master_if.sv | 27 ++
 rtl/myspi_clkgen.sv | 47 ++++
 rtl/myspi_master.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/myspi_pkg.sv
// myspi_pkg: shared types and widths for the myspi_master SPI register master.
// The frame is {write flag, address, data}, sent MSB first.
package myspi_pkg;

   localparam int FRAME_W = 32;
   localparam int DATA_W  = 16;
   localparam int ADDR_W  = 15;
   localparam int WR_BIT  = 31;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_GAP   = 3'd4
   } state_e;

   // Read frames carry zero in the data field regardless of the request's wdata.
   function automatic logic [FRAME_W-1:0] build_frame(input logic             wr,
                                                      input logic [ADDR_W-1:0] addr,
                                                      input logic [DATA_W-1:0] wdata);
      return {wr, addr, (wr ? wdata : {DATA_W{1'b0}})};
   endfunction

endpackage

// File: rtl/myspi_master_if.sv
// myspi_master_if: request/response bus of myspi_master.
// rsp_err exists only when MYSPI_MASTER_VERIFY_EN is defined.
interface myspi_master_if;
   import myspi_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
`ifdef MYSPI_MASTER_VERIFY_EN
   logic              rsp_err;

   modport slave  (input  req_valid, req_write, req_addr, req_wdata,
                   output req_ready, rsp_valid, rsp_rdata, rsp_err);
   modport master (output req_valid, req_write, req_addr, req_wdata,
                   input  req_ready, rsp_valid, rsp_rdata, rsp_err);
`else
   modport slave  (input  req_valid, req_write, req_addr, req_wdata,
                   output req_ready, rsp_valid, rsp_rdata);
   modport master (output req_valid, req_write, req_addr, req_wdata,
                   input  req_ready, rsp_valid, rsp_rdata);
`endif

endinterface

// File: rtl/myspi_clkgen.sv
// myspi_clkgen: idle-low SCLK generator for myspi_master. rise_o/fall_o fire
// in the last cycle of a half-period, i.e. on the edge where SCLK changes.
module myspi_clkgen #(
   parameter int HALF_PERIOD = 8
) (
   input  logic theClock,
   input  logic theReset,
   input  logic en_i,
   output logic sclk_o,
   output logic rise_o,
   output logic fall_o
);

   logic [7:0] hcnt_q, hcnt_d;
   logic       sclk_q, sclk_d;
   logic       last_s;

   assign last_s = (hcnt_q == 8'(HALF_PERIOD - 1));
   assign rise_o = en_i && !sclk_q && last_s;
   assign fall_o = en_i &&  sclk_q && last_s;
   assign sclk_o = sclk_q;

   always_comb begin
      hcnt_d = hcnt_q;
      sclk_d = sclk_q;
      if (!en_i) begin
         hcnt_d = 8'd0;
         sclk_d = 1'b0;
      end else if (last_s) begin
         hcnt_d = 8'd0;
         sclk_d = !sclk_q;
      end else begin
         hcnt_d = hcnt_q + 8'd1;
      end
   end

   always_ff @(posedge theClock) begin
      if (theReset) begin
         hcnt_q <= 8'd0;
         sclk_q <= 1'b0;
      end else begin
         hcnt_q <= hcnt_d;
         sclk_q <= sclk_d;
      end
   end

endmodule

// File: rtl/myspi_master.sv
// myspi_master: 32-bit SPI register master (SCLK idle low, MSB first).
// Define MYSPI_MASTER_VERIFY_EN to add automatic write readback and rsp_err.
module myspi_master
   import myspi_pkg::*;
#(
   parameter int HALF_PERIOD = 8,
   parameter int CS_SETUP    = 4,
   parameter int CS_GAP      = 8
) (
   input  logic          theClock,
   input  logic          theReset,
   myspi_master_if.slave bus,
   output logic          Master_clk,
   output logic          Master_cs,
   output logic          Master_mosi,
   input  logic          Master_miso
);

   state_e             state_q, state_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [4:0]         bit_q, bit_d;
   logic [FRAME_W-1:0] tx_q, tx_d;
   logic [DATA_W-1:0]  rx_q, rx_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic               cs_q, cs_d;
   logic               mosi_q, mosi_d;
   logic               ready_q, ready_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic               accept_s, shift_en_s, rise_s, fall_s;
   logic [FRAME_W-1:0] frame_s;
`ifdef MYSPI_MASTER_VERIFY_EN
   logic               wr_q, wr_d;
   logic               pend_q, pend_d;
   logic               err_q, err_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic [7:0]         gap_last_s;

   // The readback skips IDLE, so its gap is stretched by one cycle to match a fresh request.
   assign gap_last_s = pend_q ? 8'(CS_GAP) : 8'(CS_GAP - 1);
   assign bus.rsp_err = err_q;
`endif

   assign accept_s   = bus.req_valid && ready_q;
   assign frame_s    = build_frame(bus.req_write, bus.req_addr, bus.req_wdata);
   assign shift_en_s = (state_q == ST_SHIFT);

   myspi_clkgen #(.HALF_PERIOD(HALF_PERIOD)) u_clkgen (
      .theClock (theClock),
      .theReset (theReset),
      .en_i     (shift_en_s),
      .sclk_o   (Master_clk),
      .rise_o   (rise_s),
      .fall_o   (fall_s)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_d       = bit_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      rdata_d     = rdata_q;
      cs_d        = cs_q;
      mosi_d      = mosi_q;
      ready_d     = ready_q;
      rsp_valid_d = 1'b0;
`ifdef MYSPI_MASTER_VERIFY_EN
      wr_d    = wr_q;
      pend_d  = pend_q;
      err_d   = err_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               state_d = ST_SETUP;
               cs_d    = 1'b0;
               ready_d = 1'b0;
               cnt_d   = 8'd0;
               bit_d   = 5'd0;
               tx_d    = frame_s;
               mosi_d  = frame_s[WR_BIT];
`ifdef MYSPI_MASTER_VERIFY_EN
               wr_d    = bus.req_write;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               pend_d  = 1'b0;
`endif
            end else begin
               cs_d   = 1'b1;
               mosi_d = 1'b0;
            end
         end
         ST_SETUP: begin
            if (cnt_q == 8'(CS_SETUP - 1)) begin
               state_d = ST_SHIFT;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_SHIFT: begin
            // Only bit counts 16..31 carry the 16 data bits of the response.
            if (rise_s && bit_q[4]) begin
               rx_d = {rx_q[DATA_W-2:0], Master_miso};
            end else begin
               rx_d = rx_q;
            end
            if (fall_s) begin
               if (bit_q == 5'd31) begin
                  state_d = ST_HOLD;
                  cnt_d   = 8'd0;
                  bit_d   = 5'd0;
                  mosi_d  = 1'b0;
               end else begin
                  bit_d  = bit_q + 5'd1;
                  tx_d   = tx_q << 5'd1;
                  mosi_d = tx_d[FRAME_W-1];
               end
            end else begin
               bit_d = bit_q;
            end
         end
         ST_HOLD: begin
            if (cnt_q == 8'(CS_SETUP - 1)) begin
               state_d = ST_GAP;
               cnt_d   = 8'd0;
               cs_d    = 1'b1;
`ifdef MYSPI_MASTER_VERIFY_EN
               if (wr_q) begin
                  pend_d = 1'b1;
               end else begin
                  rsp_valid_d = 1'b1;
                  rdata_d     = rx_q;
                  err_d       = pend_q && (rx_q != wdata_q);
                  pend_d      = 1'b0;
               end
`else
               rsp_valid_d = 1'b1;
               rdata_d     = rx_q;
`endif
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_GAP: begin
`ifdef MYSPI_MASTER_VERIFY_EN
            if (cnt_q == gap_last_s) begin
               cnt_d = 8'd0;
               if (pend_q) begin
                  state_d = ST_SETUP;
                  cs_d    = 1'b0;
                  wr_d    = 1'b0;
                  bit_d   = 5'd0;
                  tx_d    = build_frame(1'b0, addr_q, wdata_q);
                  mosi_d  = 1'b0;
               end else begin
                  state_d = ST_IDLE;
                  ready_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`else
            if (cnt_q == 8'(CS_GAP - 1)) begin
               cnt_d   = 8'd0;
               state_d = ST_IDLE;
               ready_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
            bit_d   = 5'd0;
            cs_d    = 1'b1;
            mosi_d  = 1'b0;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge theClock) begin
      if (theReset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 8'd0;
         bit_q       <= 5'd0;
         tx_q        <= {FRAME_W{1'b0}};
         rx_q        <= {DATA_W{1'b0}};
         rdata_q     <= {DATA_W{1'b0}};
         cs_q        <= 1'b1;
         mosi_q      <= 1'b0;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
`ifdef MYSPI_MASTER_VERIFY_EN
         wr_q    <= 1'b0;
         pend_q  <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= {ADDR_W{1'b0}};
         wdata_q <= {DATA_W{1'b0}};
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         rdata_q     <= rdata_d;
         cs_q        <= cs_d;
         mosi_q      <= mosi_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
`ifdef MYSPI_MASTER_VERIFY_EN
         wr_q    <= wr_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
`endif
      end
   end

   assign Master_cs     = cs_q;
   assign Master_mosi   = mosi_q;
   assign bus.req_ready = ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rdata_q;

endmodule
